// File: rtl/tdm_demux_8_pkg.sv
// Shared constants and types for the 8-channel TDM receive path.
// Channel count, slot width, FSM encodings and the default miss limit.
package tdm_demux_8_pkg;

  localparam int NUM_CH       = 8;
  localparam int SLOT_W       = 3;
  localparam int MISS_MAX_DEF = 2;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_RECV = 1'b1
  } state_e;

endpackage

// File: rtl/tdm_demux_8_slot_counter.sv
// slot_counter_3b: 3-bit slot counter, clear-to-0, load-to-1, enable.
// Ports: clk, rst_n (sync), en, load1, clr -> count, wrap (count==7 & en).
module slot_counter_3b
  import tdm_demux_8_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load1,
  input  logic              clr,
  output logic [SLOT_W-1:0] count,
  output logic              wrap
);

  logic [SLOT_W-1:0] count_q;
  logic [SLOT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load1) begin
      count_d = SLOT_W'(1);
    end else if (en) begin
      count_d = count_q + SLOT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign wrap  = en & (count_q == '1);

endmodule

// File: rtl/tdm_demux_8.sv
// TDM receive demux: aligns on in_sync, stages 8 slot bits, emits a word.
// Ports: clk, rst_n, in_bit, in_valid, in_sync -> slot, out, out_valid, locked, sync_err.
module tdm_demux_8
  import tdm_demux_8_pkg::*;
#(
  parameter int MISS_MAX = MISS_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_bit,
  input  logic              in_valid,
  input  logic              in_sync,
  output logic [SLOT_W-1:0] slot,
  output logic [NUM_CH-1:0] out,
  output logic              out_valid,
  output logic              locked,
  output logic              sync_err
);

  localparam logic [2:0] MISS_LIM = 3'(MISS_MAX);

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] stage_q, stage_d;
  logic [2:0]        miss_q, miss_d;
  logic [2:0]        miss_inc;
  logic [NUM_CH-1:0] out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              sync_err_q, sync_err_d;
  logic              cnt_en, cnt_ld, cnt_clr;
  logic              wrap;
  logic              is_s0, early, lost;

  slot_counter_3b u_slot (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cnt_en),
    .load1 (cnt_ld),
    .clr   (cnt_clr),
    .count (slot),
    .wrap  (wrap)
  );

  assign miss_inc = (miss_q >= MISS_LIM) ? MISS_LIM : miss_q + 3'd1;
  assign is_s0    = (slot == '0);
  assign early    = ~is_s0 & in_sync;
  assign lost     = is_s0 & ~in_sync & (miss_inc == MISS_LIM);

  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    miss_d     = miss_q;
    sync_err_d = 1'b0;
    cnt_en     = 1'b0;
    cnt_ld     = 1'b0;
    cnt_clr    = 1'b0;
    if (in_valid) begin
      if (state_q == ST_HUNT) begin
        if (in_sync) begin
          stage_d = {{(NUM_CH-1){1'b0}}, in_bit};
          miss_d  = '0;
          cnt_ld  = 1'b1;
          state_d = ST_RECV;
        end
      end else begin
        unique case (1'b1)
          early: begin
            sync_err_d = 1'b1;
            stage_d    = {{(NUM_CH-1){1'b0}}, in_bit};
            miss_d     = '0;
            cnt_ld     = 1'b1;
          end
          lost: begin
            sync_err_d = 1'b1;
            miss_d     = miss_inc;
            cnt_clr    = 1'b1;
            state_d    = ST_HUNT;
          end
          default: begin
            stage_d[slot] = in_bit;
            cnt_en        = 1'b1;
            if (is_s0) begin
              miss_d = in_sync ? 3'd0 : miss_inc;
            end
          end
        endcase
      end
    end
  end

  // wrap only fires on a normal slot-7 store, so completion
  // and framing errors are mutually exclusive.
  always_comb begin
    out_valid_d = wrap;
    out_d       = wrap ? {in_bit, stage_q[NUM_CH-2:0]} : out_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_HUNT;
      stage_q     <= '0;
      miss_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      miss_q      <= miss_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign sync_err  = sync_err_q;
  assign locked    = (state_q == ST_RECV);

endmodule

// File: tb/tb_tdm_demux_8.sv
// Self-checking bench for tdm_demux_8: vector table plus corner sequences.
// Drives on negedge, samples 1 time unit after posedge.
module tb_tdm_demux_8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_sync = 1'b0;
  logic [2:0] slot;
  logic [7:0] out_w;
  logic       out_valid;
  logic       locked;
  logic       sync_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tdm_demux_8 #(.MISS_MAX(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_sync   (in_sync),
    .slot      (slot),
    .out       (out_w),
    .out_valid (out_valid),
    .locked    (locked),
    .sync_err  (sync_err)
  );

  typedef struct {
    logic       rst;
    logic       vld;
    logic       syn;
    logic       b;
    logic [2:0] e_slot;
    logic [7:0] e_out;
    logic       e_ov;
    logic       e_lk;
    logic       e_se;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic rst, logic vld, logic syn, logic b,
    logic [2:0] es, logic [7:0] eo,
    logic eov, logic elk, logic ese);
    vec_t v;
    v.rst = rst; v.vld = vld; v.syn = syn; v.b = b;
    v.e_slot = es; v.e_out = eo;
    v.e_ov = eov; v.e_lk = elk; v.e_se = ese;
    return v;
  endfunction

  task automatic step(logic rst, logic vld, logic syn, logic b);
    @(negedge clk);
    rst_n = rst; in_valid = vld; in_sync = syn; in_bit = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check(string nm, logic [2:0] es, logic [7:0] eo,
                       logic eov, logic elk, logic ese);
    tests++;
    if (slot !== es || out_w !== eo || out_valid !== eov ||
        locked !== elk || sync_err !== ese) begin
      fails++;
      $display("FAIL %s: got slot=%0d out=%h ov=%b lk=%b se=%b exp slot=%0d out=%h ov=%b lk=%b se=%b",
               nm, slot, out_w, out_valid, locked, sync_err,
               es, eo, eov, elk, ese);
    end
  endtask

  // frame helper: slot bits b0..b7 of w, sync on slot 0 if s
  task automatic frame(string nm, logic [7:0] w, logic s,
                       logic [7:0] prev, logic lk);
    for (int k = 0; k < 8; k++) begin
      logic [7:0] wv;
      wv = w;
      step(1'b1, 1'b1, (k == 0) ? s : 1'b0, wv[k]);
      if (k == 7) check(nm, 3'd0, w, 1'b1, lk, 1'b0);
      else check(nm, 3'(k + 1), prev, 1'b0, lk, 1'b0);
    end
  endtask

  initial begin
    // test 1: reset then 0xA5 back to back
    tbl.push_back(mk(0,0,0,0, 0,8'h00,0,0,0));
    tbl.push_back(mk(1,1,1,1, 1,8'h00,0,1,0));
    tbl.push_back(mk(1,1,0,0, 2,8'h00,0,1,0));
    tbl.push_back(mk(1,1,0,1, 3,8'h00,0,1,0));
    tbl.push_back(mk(1,1,0,0, 4,8'h00,0,1,0));
    tbl.push_back(mk(1,1,0,0, 5,8'h00,0,1,0));
    tbl.push_back(mk(1,1,0,1, 6,8'h00,0,1,0));
    tbl.push_back(mk(1,1,0,0, 7,8'h00,0,1,0));
    tbl.push_back(mk(1,1,0,1, 0,8'hA5,1,1,0));
    tbl.push_back(mk(1,0,0,0, 0,8'hA5,0,1,0));
    // test 2: 0xA5 with a 3-cycle gap after slot 3
    tbl.push_back(mk(1,1,1,1, 1,8'hA5,0,1,0));
    tbl.push_back(mk(1,1,0,0, 2,8'hA5,0,1,0));
    tbl.push_back(mk(1,1,0,1, 3,8'hA5,0,1,0));
    tbl.push_back(mk(1,1,0,0, 4,8'hA5,0,1,0));
    tbl.push_back(mk(1,0,1,1, 4,8'hA5,0,1,0));
    tbl.push_back(mk(1,0,0,1, 4,8'hA5,0,1,0));
    tbl.push_back(mk(1,0,1,0, 4,8'hA5,0,1,0));
    tbl.push_back(mk(1,1,0,0, 5,8'hA5,0,1,0));
    tbl.push_back(mk(1,1,0,1, 6,8'hA5,0,1,0));
    tbl.push_back(mk(1,1,0,0, 7,8'hA5,0,1,0));
    tbl.push_back(mk(1,1,0,1, 0,8'hA5,1,1,0));
    // 0x3C with sync
    tbl.push_back(mk(1,1,1,0, 1,8'hA5,0,1,0));
    tbl.push_back(mk(1,1,0,0, 2,8'hA5,0,1,0));
    tbl.push_back(mk(1,1,0,1, 3,8'hA5,0,1,0));
    tbl.push_back(mk(1,1,0,1, 4,8'hA5,0,1,0));
    tbl.push_back(mk(1,1,0,1, 5,8'hA5,0,1,0));
    tbl.push_back(mk(1,1,0,1, 6,8'hA5,0,1,0));
    tbl.push_back(mk(1,1,0,0, 7,8'hA5,0,1,0));
    tbl.push_back(mk(1,1,0,0, 0,8'h3C,1,1,0));
    // test 3: early sync on slot 5, then 7 ones -> 0xFF
    tbl.push_back(mk(1,1,1,0, 1,8'h3C,0,1,0));
    tbl.push_back(mk(1,1,0,0, 2,8'h3C,0,1,0));
    tbl.push_back(mk(1,1,0,0, 3,8'h3C,0,1,0));
    tbl.push_back(mk(1,1,0,0, 4,8'h3C,0,1,0));
    tbl.push_back(mk(1,1,0,0, 5,8'h3C,0,1,0));
    tbl.push_back(mk(1,1,1,1, 1,8'h3C,0,1,1));
    for (int k = 2; k <= 7; k++)
      tbl.push_back(mk(1,1,0,1, 3'(k),8'h3C,0,1,0));
    tbl.push_back(mk(1,1,0,1, 0,8'hFF,1,1,0));
    tbl.push_back(mk(1,0,0,0, 0,8'hFF,0,1,0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].vld, tbl[i].syn, tbl[i].b);
      check($sformatf("vec%0d", i), tbl[i].e_slot, tbl[i].e_out,
            tbl[i].e_ov, tbl[i].e_lk, tbl[i].e_se);
    end

    // test 4: two frames without sync, MISS_MAX=2
    frame("t4_0f", 8'h0F, 1'b0, 8'hFF, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("t4_lost", 3'd0, 8'h0F, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1);
      check("t4_ignore", 3'd0, 8'h0F, 1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("t4_relock", 3'd1, 8'h0F, 1'b0, 1'b1, 1'b0);

    // test 5: reset, then 20 non-sync bits in HUNT
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t5_rst", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b1, 1'b0, k[0]);
      check("t5_hunt", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    end

    // test 6: reset after slot 4 of a frame, then fresh 0x81
    step(1'b1, 1'b1, 1'b1, 1'b1);
    for (int k = 1; k <= 4; k++) step(1'b1, 1'b1, 1'b0, 1'b1);
    check("t6_part", 3'd5, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("t6_rst", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    frame("t6_81", 8'h81, 1'b1, 8'h00, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t6_hold", 3'd0, 8'h81, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tdm_demux_8.md
Name: tdm_demux_8

Overview:
- Receive end of the 8-channel time-division serial link. The transmit end scans a 3-bit select across channels 0..7 and emits one bit per slot.
- This block tracks frame alignment with a 3-bit slot counter and routes each incoming bit to its channel position.
- After all 8 slots of a frame are received, it presents a registered 8-bit parallel word with a one-cycle valid pulse.
- Sits between the serial link and the ALU operand/register-file path.

Parameters:
- MISS_MAX, 2, consecutive frames whose slot-0 bit lacks in_sync before alignment is declared lost (range 1..7).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_bit  input  1  serial data bit for the current slot.
- in_valid  input  1  in_bit/in_sync are valid this cycle; gaps allowed.
- in_sync  input  1  frame marker; qualified by in_valid; marks the slot-0 bit.
- slot  output  3  index of the slot the next accepted bit will fill.
- out  output  8  last complete frame; bit k = channel k.
- out_valid  output  1  one-cycle pulse: out updated.
- locked  output  1  high in RECV state.
- sync_err  output  1  one-cycle pulse on framing error or lock loss.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - out=8'h00, out_valid=0, sync_err=0, locked=0, slot=0.
  - Staging register=0, miss count=0, state=HUNT.
  - A reset mid-frame discards the partial frame.
- Accept = in_valid=1 at clk edge. With in_valid=0, all state holds, and out_valid and sync_err are 0.
- HUNT:
  - An accepted bit with in_sync=0 is ignored.
  - An accepted bit with in_sync=1 clears staging and miss count, sets stage[0]=in_bit, slot=1, state=RECV.
- RECV, normal operation:
  - Each accepted bit is written to stage[slot], then slot increments.
- RECV, slot==7 accept:
  - out <= {in_bit, stage[6:0]}.
  - out_valid=1 in the following cycle, for exactly one cycle.
  - slot wraps to 0; state stays RECV.
- RECV, slot==0 accept:
  - in_sync=1: miss count cleared.
  - in_sync=0 (flywheel): miss count increments.
  - If the incremented count equals MISS_MAX: the bit is discarded, state goes to HUNT, slot=0, sync_err pulses, and there is no output.
  - Otherwise: the bit is stored normally.
- RECV, slot!=0 accept with in_sync=1 (early sync):
  - sync_err pulses and the partial frame is discarded (no out_valid).
  - Staging is cleared, stage[0]=in_bit, slot=1, miss count cleared; state stays RECV.
- Simultaneous events:
  - A slot-7 completion and the next frame's slot-0 bit never occur in the same cycle (one bit per cycle).
  - out_valid and sync_err are never both high.
- Output holding: out holds its value until the next completed frame; partial frames never modify out.
- Latency: out_valid is 1 clk after the slot-7 accept. Minimum frame period is 8 clks.
- locked = (state==RECV), registered.
- Width rules:
  - slot counter is exactly 3 bits with natural wrap 7->0.
  - miss count is 3 bits and saturates at MISS_MAX.

Decomposition:
- Shared header/package:
  - NUM_CH=8, SLOT_W=3.
  - State encodings ST_HUNT=1'b0, ST_RECV=1'b1.
  - MISS_MAX default.
- One sub-module: slot_counter_3b, a 3-bit counter with enable, synchronous load-to-1, clear-to-0, and a wrap flag (count==7 and enable).
- Staging register, FSM and output register stay in tdm_demux_8.

Test Plan:
1. Reset, then a sync on slot 0 and frame bits slot0..7 = 1,0,1,0,0,1,0,1, back to back -> out=8'hA5, out_valid high exactly 1 cycle after the 8th bit, locked=1.
2. Same frame 0xA5 with in_valid=0 inserted for 3 cycles between slots 3 and 4 -> out=8'hA5 and slot holds at 4 during the gap. A following frame 0x3C with sync -> out=8'h3C.
3. Locked, then in_sync asserted on slot 5 -> sync_err 1-cycle pulse, no out_valid, slot=1. The next 7 bits complete a frame 0xFF (bits all 1) -> out=8'hFF.
4. Locked, MISS_MAX=2, two consecutive frames without in_sync:
   - First frame (0x0F) completes as out=8'h0F.
   - The second slot-0 bit causes sync_err and locked=0, slot=0.
   - Subsequent non-sync bits are ignored until in_sync.
5. Bits are streamed in HUNT with in_sync=0 for 20 cycles -> out stays 8'h00, out_valid never asserts, slot=0.
6. rst_n=0 after slot 4 of a frame, then a fresh sync frame 0x81 -> outputs return to their reset values, and only out=8'h81 is reported (no stale bits).
